// File: rtl/line_follow_ctrl.sv
// Drive-decision stage for the line-following car: filters the tracker bits, runs the
// follow/search/halt/blocked FSM and decodes motor direction codes plus a speed mode.
module line_follow_ctrl #(
  parameter int unsigned FILT_CYCLES  = 1000,
  parameter int unsigned LOST_TIMEOUT = 50_000_000,
  parameter int unsigned RESUME_DELAY = 10_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       left_signal,
  input  logic       mid_signal,
  input  logic       right_signal,
  input  logic       stop,
  output logic [1:0] left,
  output logic [1:0] right,
  output logic [1:0] mode,
  output logic [2:0] state
);

  localparam int unsigned FiltW = $clog2(FILT_CYCLES + 1);
  localparam int unsigned LostW = $clog2(LOST_TIMEOUT + 1);
  localparam int unsigned ResW  = $clog2(RESUME_DELAY + 1);

  localparam logic [FiltW-1:0] FiltMax  = FiltW'(FILT_CYCLES);
  localparam logic [LostW-1:0] LostLast = LostW'(LOST_TIMEOUT - 1);
  localparam logic [ResW-1:0]  ResLast  = ResW'(RESUME_DELAY - 1);

  localparam logic [1:0] DirFwd   = 2'b10;
  localparam logic [1:0] DirRev   = 2'b01;
  localparam logic [1:0] DirBrake = 2'b00;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StFwd     = 3'd1,
    StTurnL   = 3'd2,
    StTurnR   = 3'd3,
    StSearch  = 3'd4,
    StHalt    = 3'd5,
    StBlocked = 3'd6
  } state_e;

  logic [2:0]       raw;
  logic [2:0]       sync1_q, sync2_q, cand_q;
  logic [2:0]       sens_q, sens_d;
  logic [FiltW-1:0] filt_cnt_q, filt_cnt_d, run_len;

  state_e           state_q, state_d, dec_st;
  logic             dec_lost, dec_hold;
  logic [LostW-1:0] lost_cnt_q, lost_cnt_d;
  logic [ResW-1:0]  res_cnt_q, res_cnt_d;
  logic             last_dir_q, last_dir_d;  // 0 = left, 1 = right

  assign raw = {left_signal, mid_signal, right_signal};

  // run_len is how many consecutive cycles the synchronized vector has held its value.
  always_comb begin
    sens_d     = sens_q;
    filt_cnt_d = '0;
    run_len    = (sync2_q == cand_q) ? filt_cnt_q + FiltW'(1) : FiltW'(1);
    if (sync2_q != sens_q) begin
      if (run_len >= FiltMax) begin
        sens_d = sync2_q;
      end else begin
        filt_cnt_d = run_len;
      end
    end
  end

  always_comb begin
    dec_st   = StFwd;
    dec_lost = 1'b0;
    dec_hold = 1'b0;
    unique case (sens_q)
      3'b010, 3'b111: dec_st = StFwd;
      3'b110, 3'b100: dec_st = StTurnL;
      3'b011, 3'b001: dec_st = StTurnR;
      3'b000:         dec_lost = 1'b1;
      default:        dec_hold = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = StIdle;
    end else if (stop && (state_q != StIdle)) begin
      state_d = StBlocked;
    end else begin
      case (state_q)
        StIdle: begin
          if (!stop) begin
            if (dec_lost)      state_d = StHalt;
            else if (!dec_hold) state_d = dec_st;
          end
        end
        StFwd, StTurnL, StTurnR: begin
          if (dec_lost)       state_d = StSearch;
          else if (!dec_hold) state_d = dec_st;
        end
        StSearch: begin
          if (!dec_lost && !dec_hold)    state_d = dec_st;
          else if (lost_cnt_q == LostLast) state_d = StHalt;
        end
        StHalt: begin
          if (!dec_lost && !dec_hold) state_d = dec_st;
        end
        StBlocked: begin
          // An ambiguous reading keeps us parked with the resume count saturated.
          if (res_cnt_q == ResLast) begin
            if (dec_lost)       state_d = StSearch;
            else if (!dec_hold) state_d = dec_st;
          end
        end
        default: state_d = StIdle;
      endcase
    end

    lost_cnt_d = ((state_q == StSearch) && (state_d == StSearch)) ?
                 lost_cnt_q + LostW'(1) : '0;

    res_cnt_d = '0;
    if ((state_q == StBlocked) && (state_d == StBlocked) && !stop) begin
      res_cnt_d = (res_cnt_q == ResLast) ? res_cnt_q : res_cnt_q + ResW'(1);
    end

    last_dir_d = last_dir_q;
    if (state_d == StTurnL)      last_dir_d = 1'b0;
    else if (state_d == StTurnR) last_dir_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      cand_q     <= '0;
      sens_q     <= '0;
      filt_cnt_q <= '0;
      state_q    <= StIdle;
      lost_cnt_q <= '0;
      res_cnt_q  <= '0;
      last_dir_q <= 1'b0;
    end else begin
      sync1_q    <= raw;
      sync2_q    <= sync1_q;
      cand_q     <= sync2_q;
      sens_q     <= sens_d;
      filt_cnt_q <= filt_cnt_d;
      state_q    <= state_d;
      lost_cnt_q <= lost_cnt_d;
      res_cnt_q  <= res_cnt_d;
      last_dir_q <= last_dir_d;
    end
  end

  always_comb begin
    left  = DirBrake;
    right = DirBrake;
    mode  = 2'd0;
    case (state_q)
      StFwd: begin
        left  = DirFwd;
        right = DirFwd;
        mode  = 2'd3;
      end
      StTurnL: begin
        left  = DirRev;
        right = DirFwd;
        mode  = 2'd2;
      end
      StTurnR: begin
        left  = DirFwd;
        right = DirRev;
        mode  = 2'd2;
      end
      StSearch: begin
        left  = last_dir_q ? DirFwd : DirRev;
        right = last_dir_q ? DirRev : DirFwd;
        mode  = 2'd1;
      end
      default: ;
    endcase
  end

  assign state = state_q;

endmodule

// File: tb/tb_line_follow_ctrl.sv
// Bench for line_follow_ctrl: directed scenarios with literal expectations plus a random
// phase, all cross-checked every cycle against a behavioural model of the car's decisions.
module tb_line_follow_ctrl;

  localparam int unsigned FILT = 4;
  localparam int unsigned LT   = 20;
  localparam int unsigned RD   = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b1;
  logic       ls = 1'b0, ms = 1'b0, rs = 1'b0;
  logic       stop = 1'b0;
  logic [1:0] left, right, mode;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  line_follow_ctrl #(
    .FILT_CYCLES (FILT),
    .LOST_TIMEOUT(LT),
    .RESUME_DELAY(RD)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .left_signal (ls),
    .mid_signal  (ms),
    .right_signal(rs),
    .stop        (stop),
    .left        (left),
    .right       (right),
    .mode        (mode),
    .state       (state)
  );

  // 1..3 = FWD/TURN_L/TURN_R, -1 = line lost, -2 = ambiguous (hold).
  function automatic int decode(logic [2:0] s);
    case (s)
      3'b010, 3'b111: return 1;
      3'b110, 3'b100: return 2;
      3'b011, 3'b001: return 3;
      3'b000:         return -1;
      default:        return -2;
    endcase
  endfunction

  // {left, right, mode} the car should show in a given state.
  function automatic logic [5:0] outputs_for(int st, bit dir_right);
    case (st)
      1:       return 6'b10_10_11;
      2:       return 6'b01_10_10;
      3:       return 6'b10_01_10;
      4:       return dir_right ? 6'b10_01_01 : 6'b01_10_01;
      default: return 6'b00_00_00;
    endcase
  endfunction

  // Behavioural model: raw bits reach the filter two samples late; the accepted reading
  // changes once the last FILT synchronized samples agree and differ from it.
  logic [2:0] m_d1 = '0, m_d2 = '0, m_sens = '0;
  logic [2:0] win[$];
  int         m_st = 0, m_lc = 0, m_rc = 0;
  bit         m_ld = 1'b0;

  always @(posedge clk) begin : model_p
    int d;
    int nst;
    bit same;
    if (rst) begin
      m_d1 = '0; m_d2 = '0; m_sens = '0;
      win.delete();
      m_st = 0; m_lc = 0; m_rc = 0; m_ld = 1'b0;
    end else begin
      d   = decode(m_sens);
      nst = m_st;
      if (!enable)                   nst = 0;
      else if (stop && m_st != 0)    nst = 6;
      else if (m_st == 0)            nst = stop ? 0 : (d == -1) ? 5 : (d == -2) ? 0 : d;
      else if (m_st inside {1, 2, 3}) nst = (d == -1) ? 4 : (d == -2) ? m_st : d;
      else if (m_st == 4)            nst = (d > 0) ? d : (m_lc == LT - 1) ? 5 : 4;
      else if (m_st == 5)            nst = (d > 0) ? d : 5;
      else if (m_rc == RD - 1)       nst = (d == -1) ? 4 : (d == -2) ? 6 : d;

      if (m_st == 4 && nst == 4) m_lc++;
      else                       m_lc = 0;
      if (m_st == 6 && nst == 6 && !stop) m_rc = (m_rc < RD - 1) ? m_rc + 1 : m_rc;
      else                                m_rc = 0;
      if (nst == 2) m_ld = 1'b0;
      if (nst == 3) m_ld = 1'b1;
      m_st = nst;

      win.push_back(m_d2);
      if (win.size() > FILT) void'(win.pop_front());
      if (win.size() == FILT) begin
        same = 1'b1;
        foreach (win[i]) if (win[i] != win[0]) same = 1'b0;
        if (same && win[0] != m_sens) m_sens = win[0];
      end
      m_d2 = m_d1;
      m_d1 = {ls, ms, rs};
    end
  end

  always @(negedge clk) begin : compare_p
    logic [5:0] exp_o;
    exp_o = outputs_for(m_st, m_ld);
    checks++;
    if (state !== 3'(m_st) || {left, right, mode} !== exp_o) begin
      errors++;
      $display("FAIL model t=%0t: got state=%0d l=%b r=%b m=%0d, want state=%0d l=%b r=%b m=%0d",
               $time, state, left, right, mode, m_st, exp_o[5:4], exp_o[3:2], exp_o[1:0]);
    end
  end

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_now(string name, int st, logic [5:0] o);
    checks++;
    if (state !== 3'(st) || {left, right, mode} !== o) begin
      errors++;
      $display("FAIL %s: got state=%0d l=%b r=%b m=%0d, want state=%0d l=%b r=%b m=%0d",
               name, state, left, right, mode, st, o[5:4], o[3:2], o[1:0]);
    end
  endtask

  task automatic set_raw(logic [2:0] v);
    {ls, ms, rs} = v;
  endtask

  initial begin : stim_p
    logic [2:0] v;
    set_raw(3'b010);
    tick(3);
    check_now("reset_state", 0, 6'b00_00_00);
    rst = 1'b0;
    tick(1);
    check_now("idle_lost_halt", 5, 6'b00_00_00);
    tick(5);
    check_now("fwd_not_early", 5, 6'b00_00_00);
    tick(1);
    check_now("fwd_latency", 1, 6'b10_10_11);

    // Glitch to 100 for two cycles, then settle on 110.
    set_raw(3'b100);
    tick(2);
    set_raw(3'b110);
    tick(6);
    check_now("glitch_no_early", 1, 6'b10_10_11);
    tick(1);
    check_now("turn_l", 2, 6'b01_10_10);

    set_raw(3'b011);
    tick(7);
    check_now("turn_r", 3, 6'b10_01_10);
    set_raw(3'b000);
    tick(7);
    check_now("search_right", 4, 6'b10_01_01);
    tick(19);
    check_now("search_before_to", 4, 6'b10_01_01);
    tick(1);
    check_now("search_timeout", 5, 6'b00_00_00);
    set_raw(3'b010);
    tick(7);
    check_now("halt_to_fwd", 1, 6'b10_10_11);

    stop = 1'b1;
    tick(1);
    check_now("blocked", 6, 6'b00_00_00);
    stop = 1'b0;
    tick(5);
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    tick(7);
    check_now("blocked_hold", 6, 6'b00_00_00);
    tick(1);
    check_now("resume_fwd", 1, 6'b10_10_11);

    set_raw(3'b110);
    tick(7);
    check_now("turn_l_again", 2, 6'b01_10_10);
    set_raw(3'b101);
    tick(37);
    check_now("ambiguous_hold", 2, 6'b01_10_10);
    enable = 1'b0;
    tick(1);
    check_now("disable_idle", 0, 6'b00_00_00);
    enable = 1'b1;

    set_raw(3'b110);
    tick(7);
    check_now("idle_to_turn_l", 2, 6'b01_10_10);
    set_raw(3'b000);
    tick(7);
    check_now("search_left", 4, 6'b01_10_01);
    tick(5);
    set_raw(3'b010);
    tick(2);
    rst = 1'b1;
    set_raw(3'b000);
    tick(1);
    check_now("mid_reset", 0, 6'b00_00_00);
    rst = 1'b0;
    tick(1);
    check_now("post_reset_halt", 5, 6'b00_00_00);
    tick(10);
    check_now("post_reset_stay", 5, 6'b00_00_00);

    for (int i = 0; i < 300; i++) begin
      v = 3'($urandom_range(0, 7));
      set_raw(v);
      stop   = ($urandom_range(0, 7) == 0);
      enable = ($urandom_range(0, 19) != 0);
      rst    = ($urandom_range(0, 49) == 0);
      tick($urandom_range(1, 12));
    end
    rst    = 1'b0;
    stop   = 1'b0;
    enable = 1'b1;
    tick(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
